// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encodings and the GF(2^8) / state-permutation helpers
// used by the iterative inverse cipher.
package aes_pkg;

    localparam int AES_NR  = 10;
    localparam int AES_NK  = 4;
    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int KS_W    = 1408;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } dec_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
            r[119 - 32*c -: 8] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
            r[111 - 32*c -: 8] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
            r[103 - 32*c -: 8] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] round_key(input logic [KS_W-1:0] w, input logic [3:0] r);
        return w[KS_W - 1 - 128*int'(r) -: 128];
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, table lookup.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = INV_TABLE[2047 - 8*int'(a) -: 8];

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Optional AES_DEC_ZEROIZE_EN clears out on start and the state register on completion.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KS_W-1:0]    w,
    input  logic [STATE_W-1:0] in,
    output logic [STATE_W-1:0] out,
    input  logic               trigger,
    output logic               done
);

    dec_state_t         fsm, fsm_next;
    logic [3:0]         round;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] shifted, subbed, keyed;

    assign shifted = inv_shift_rows(state);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a(shifted[127 - 8*i -: 8]),
            .y(subbed[127 - 8*i -: 8])
        );
    end

    assign keyed = subbed ^ round_key(w, round);

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (trigger) fsm_next = RUN;
            RUN:     if (round == 4'd0) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Round 0 is the final round: no InvMixColumns, result goes straight to out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm   <= IDLE;
            round <= '0;
            state <= '0;
            out   <= '0;
            done  <= 1'b1;
        end else begin
            fsm <= fsm_next;
            case (fsm)
                IDLE: begin
                    if (trigger) begin
                        state <= in ^ round_key(w, 4'(NR));
                        round <= 4'(NR - 1);
                        done  <= 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
                        out   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (round == 4'd0) begin
                        out  <= keyed;
                        done <= 1'b1;
`ifdef AES_DEC_ZEROIZE_EN
                        state <= '0;
`endif
                    end else begin
                        state <= inv_mix_columns(keyed);
                        round <= round - 4'd1;
                    end
                end
                default: done <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS-197 vectors, model-derived random vectors,
// back-to-back starts, asynchronous mid-run reset and idle behaviour.
module tb_aes_decrypt;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          trigger = 1'b0;
    logic [1407:0] w = '0;
    logic [127:0]  in = '0;
    logic [127:0]  out;
    logic          done;

    int            checks = 0;
    int            fails = 0;
    int            n;
    logic [127:0]  exp_q[$];
    logic [127:0]  prev_pt = '0;
    vec_t          vecs[$];
    logic [127:0]  rk, rp;

    aes_decrypt dut (
        .clk(clk),
        .reset(reset),
        .w(w),
        .in(in),
        .out(out),
        .trigger(trigger),
        .done(done)
    );

    always #5 clk = ~clk;

    // Forward-direction reference: key expansion and encryption built from the S-box table.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_TAB[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 8*(4*c + row) -: 8] = sb(s[127 - 8*(4*((c + row) % 4) + row) -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   wk[44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 4; i++) wk[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wk[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wk[i] = wk[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407 - 32*i -: 32] = wk[i];
        return r;
    endfunction

    // m < 10: ShiftRows(SubBytes(state after round m)); m == 10: ciphertext.
    function automatic logic [127:0] fwd(input logic [1407:0] ks, input logic [127:0] pt, input int m);
        logic [127:0] s, res;
        s   = pt ^ ks[1407 -: 128];
        res = '0;
        for (int r = 1; r <= 10; r++) begin
            s = sub_shift(s);
            if (r - 1 == m) res = s;
            if (r < 10) s = mix(s);
            s = s ^ ks[1407 - 128*r -: 128];
        end
        if (m == 10) res = s;
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitDone(input int limit, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [127:0] key,
                                 input logic [127:0] ct, input logic [127:0] pt);
        int cnt;
        @(negedge clk);
        w       = expand_key(key);
        in      = ct;
        trigger = 1'b1;
        exp_q.push_back(pt);
        @(negedge clk);
        trigger = 1'b0;
        in      = ~ct;
        checkOutput({name, "_busy"}, {127'd0, done}, 128'd0);
`ifdef AES_DEC_ZEROIZE_EN
        checkOutput({name, "_out_during_run"}, out, 128'd0);
`else
        checkOutput({name, "_out_during_run"}, out, prev_pt);
`endif
        waitDone(40, cnt);
        checkOutput({name, "_latency"}, 128'(cnt), 128'd10);
        checkOutput({name, "_pt"}, out, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
`ifdef AES_DEC_ZEROIZE_EN
        checkOutput({name, "_state_zeroized"}, dut.state, 128'd0);
`endif
        prev_pt = pt;
    endtask

    initial begin
        vecs.push_back('{name: "appc1", key: KEY_C, ct: CT_C, pt: PT_C});
        vecs.push_back('{name: "appb", key: KEY_B, ct: CT_B, pt: PT_B});
        vecs.push_back('{name: "zero", key: 128'd0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'd0});
        vecs.push_back('{name: "ones", key: '1, ct: fwd(expand_key('1), '1, 10), pt: '1});
        for (int i = 0; i < 3; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs.push_back('{name: $sformatf("rand%0d", i), key: rk, ct: fwd(expand_key(rk), rp, 10), pt: rp});
        end

        // Power-up reset and idle without trigger
        #12;
        checkOutput("reset_out", out, 128'd0);
        checkOutput("reset_done", {127'd0, done}, 128'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_done", {127'd0, done}, 128'd1);
            checkOutput("idle_out", out, 128'd0);
        end

        foreach (vecs[i]) applyStimulus(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt);

        // App. B with intermediate state after E0 and E1
        @(negedge clk);
        w       = expand_key(KEY_B);
        in      = CT_B;
        trigger = 1'b1;
        exp_q.push_back(PT_B);
        @(negedge clk);
        trigger = 1'b0;
        checkOutput("appb_e0_state", dut.state, fwd(expand_key(KEY_B), PT_B, 9));
        @(negedge clk);
        checkOutput("appb_e1_state", dut.state, fwd(expand_key(KEY_B), PT_B, 8));
        waitDone(40, n);
        checkOutput("appb_trace_latency", 128'(n), 128'd9);
        checkOutput("appb_trace_pt", out, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
        prev_pt = PT_B;

        // Back-to-back with trigger held high throughout
        @(negedge clk);
        w       = expand_key(KEY_C);
        in      = CT_C;
        trigger = 1'b1;
        exp_q.push_back(PT_C);
        @(negedge clk);
        waitDone(40, n);
        checkOutput("b2b_first_latency", 128'(n), 128'd10);
        checkOutput("b2b_first_pt", out, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
        w  = expand_key(KEY_B);
        in = CT_B;
        exp_q.push_back(PT_B);
        @(negedge clk);
        checkOutput("b2b_restart", {127'd0, done}, 128'd0);
        waitDone(40, n);
        trigger = 1'b0;
        checkOutput("b2b_second_latency", 128'(n), 128'd10);
        checkOutput("b2b_second_pt", out, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
        @(negedge clk);
        checkOutput("b2b_no_third", {127'd0, done}, 128'd1);
        prev_pt = PT_B;

        // Asynchronous reset at round 5
        @(negedge clk);
        w       = expand_key(KEY_C);
        in      = CT_C;
        trigger = 1'b1;
        exp_q.push_back(PT_C);
        @(negedge clk);
        trigger = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_round", {124'd0, dut.round}, 128'd5);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_out", out, 128'd0);
        checkOutput("rst_mid_done", {127'd0, done}, 128'd1);
        exp_q.delete();
        prev_pt = '0;
        #1 reset = 1'b0;
        applyStimulus("after_reset", KEY_B, CT_B, PT_B);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/aes_decrypt.md
Name: aes_decrypt

Overview:
Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt-direction counterpart of the encryption module.
- Consumes the 44-word expanded key schedule from aes_key, plus a 128-bit ciphertext.
- Produces plaintext, one inverse round per clock.
- Same trigger/done handshake as the rest of the AES blocks, so a decrypt-capable top can sequence it after key expansion.

Parameters:
NR, 10, number of rounds (fixed for AES-128; any other value is unsupported)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
w  input  1408  expanded key schedule; word i = w[1407-32*i -: 32]; round key r = w[1407-128*r -: 128]
in  input  128  ciphertext; in[127:120] = byte 0 (FIPS-197 input order, column-major)
out  output  128  plaintext, same byte order as in; registered
trigger  input  1  start request, sampled only in IDLE
done  output  1  high when idle / result valid; registered

Behaviour:
- Reset (async, reset=1):
  - FSM goes to IDLE; round counter = 0; state register = 0.
  - out = 128'h0; done = 1.
  - Asserting reset mid-operation aborts immediately and gives the same values.
- FSM states:
  - IDLE: on edge with trigger=1, state <= in ^ rk(10); round <= 9; done <= 0; go to RUN. Otherwise hold.
  - RUN, round 9..1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk(round))); round <= round-1.
  - RUN, round 0: out <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk(0)); done <= 1; go to IDLE. There is no InvMixColumns in this final round.
  - Unused encodings return to IDLE.
- Latency:
  - Accepting edge E0, then round edges E1..E10.
  - done rises and out is valid after E10, i.e. 10 cycles after the accepting edge.
  - Back-to-back: a trigger sampled on the cycle done is high starts the next operation (11-cycle period).
- Handshake rules:
  - `in` is sampled only at E0.
  - `w` is read combinationally every RUN cycle; it must remain stable from E0 through E10.
  - trigger during RUN is ignored; no queuing.
  - out holds its last value until the next completion; it is unchanged during RUN.
- Datapath:
  - 16 parallel inverse S-box lookups.
  - InvMixColumns uses xtime-based GF(2^8) multiplies by 09/0b/0d/0e, reduction polynomial 0x11b.
  - All operations are pure 8-bit byte-wise; no carries across bytes.
- Round key indexing: 4-bit round counter; only values 0..9 occur in RUN.

Optional Feature:
AES_DEC_ZEROIZE_EN
- Defined:
  - On the completion edge (E10) the internal state register is cleared to 0.
  - On the accepting edge (E0) out is cleared to 0, so stale plaintext is never visible while busy.
- Undefined:
  - The state register retains its last intermediate value.
  - out holds the previous plaintext through the next operation until overwritten at completion.
- Latency and the done timing are identical in both cases.

Decomposition:
- Package aes_pkg holds:
  - AES_NR=10, AES_NK=4, and state/word/key-schedule widths (128/32/1408).
  - FSM state encodings (IDLE, RUN).
  - Functions xtime, gf_mul9/b/d/e, inv_shift_rows, inv_mix_columns, and round-key slice.
- One sub-module: aes_inv_sbox, a combinational 8-bit-in/8-bit-out inverse S-box table, instantiated 16 times.

Test Plan:
- FIPS-197 App. C.1, w generated by aes_key from key 000102030405060708090a0b0c0d0e0f:
  - in=69c4e0d86a7b0430d8cdb78070b4c55a, trigger pulse → done=0 next cycle.
  - done=1 exactly 10 cycles after the accepting edge, out=00112233445566778899aabbccddeeff.
- FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c:
  - in=3925841d02dc09fbdc118597196a0b32 → out=3243f6a8885a308d313198a2e0370734.
  - Check intermediate state after E1 against the App. B round-9 inverse trace.
- Back-to-back:
  - Hold trigger=1 continuously; App. C.1 vector, then App. B vector loaded when done is high.
  - Two results at 11-cycle spacing, both correct; trigger during RUN ignored (no third start mid-run).
- Reset mid-operation:
  - Assert reset asynchronously (between edges) at round 5.
  - out=0 and done=1 immediately, without waiting for a clock edge.
  - A new trigger after deassertion yields a correct result.
- Reset values: after power-up reset, out=128'h0, done=1; no activity without trigger for 20 cycles.
- Zeroize: with AES_DEC_ZEROIZE_EN, out=0 from the cycle after E0 until E10, and the internal state=0 after E10; without the macro, out keeps the prior plaintext during RUN.
